// File: rtl/prim_burst_arbiter_if.sv
// Requester/sink bundle for prim_burst_arbiter: master drives requests and sink ready,
// slave (the arbiter) drives grants and the selected beat.
interface prim_burst_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32
);
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]         req_i;
    logic [N-1:0]         last_i;
    logic [N-1:0][DW-1:0] data_i;
    logic [N-1:0]         gnt_o;
    logic [IdxW-1:0]      idx_o;
    logic                 valid_o;
    logic [DW-1:0]        data_o;
    logic                 last_o;
    logic                 ready_i;
    logic                 locked_o;
    logic                 err_o;

    modport master (
        output req_i, last_i, data_i, ready_i,
        input  gnt_o, idx_o, valid_o, data_o, last_o, locked_o, err_o
    );

    modport slave (
        input  req_i, last_i, data_i, ready_i,
        output gnt_o, idx_o, valid_o, data_o, last_o, locked_o, err_o
    );
endinterface

// File: rtl/prim_burst_arbiter.sv
// N:1 burst-locking round-robin arbiter; a winner keeps the sink until last beat or MaxBeats.
// Optional stall timeout: define PRIM_BURST_ARB_TIMEOUT_EN.
module prim_burst_arbiter #(
    parameter int unsigned N             = 4,
    parameter int unsigned DW            = 32,
    parameter int unsigned MaxBeats      = 16,
    parameter int unsigned TimeoutCycles = 256,
    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned BeatW = $clog2(MaxBeats + 1)
) (
    input logic                clk_i,
    input logic                rst_ni,
    prim_burst_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE,
        LOCK
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [BeatW-1:0] beat_q, beat_d;

    logic            any_req;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic            hs;

    logic [N-1:0]    gnt;
    logic [IdxW-1:0] idx;
    logic            valid;
    logic [DW-1:0]   data;
    logic            last;
    logic            err;

`ifdef PRIM_BURST_ARB_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TimeoutCycles);
    logic [StallW-1:0] stall_q, stall_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
`endif

    // Round-robin scan starting one past the last burst owner.
    always_comb begin
        any_req = 1'b0;
        win_idx = ptr_q;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % N);
            if (!any_req && bus.req_i[cand]) begin
                any_req = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        gnt     = '0;
        idx     = ptr_q;
        valid   = 1'b0;
        data    = '0;
        last    = 1'b0;
        err     = 1'b0;
        hs      = 1'b0;
`ifdef PRIM_BURST_ARB_TIMEOUT_EN
        stall_d = stall_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    valid = 1'b1;
                    idx   = win_idx;
                    data  = bus.data_i[win_idx];
                    last  = bus.last_i[win_idx] | (MaxBeats == 1);
                    if (bus.ready_i) begin
                        gnt[win_idx] = 1'b1;
                        if (last) begin
                            ptr_d = win_idx;
                        end else begin
                            state_d = LOCK;
                            owner_d = win_idx;
                            beat_d  = BeatW'(1);
                        end
                    end else begin
                        // Decision is frozen here so later higher-priority requests cannot steal it.
                        state_d = LOCK;
                        owner_d = win_idx;
                        beat_d  = '0;
                    end
                end
            end
            LOCK: begin
                valid = bus.req_i[owner_q];
                idx   = owner_q;
                data  = bus.data_i[owner_q];
                last  = bus.last_i[owner_q] | (beat_q == BeatW'(MaxBeats - 1));
                hs    = valid & bus.ready_i;
                if (hs) begin
                    gnt[owner_q] = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        ptr_d   = owner_q;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
`ifdef PRIM_BURST_ARB_TIMEOUT_EN
                if (hs) begin
                    stall_d = '0;
                end else if (stall_q == StallW'(TimeoutCycles - 1)) begin
                    err     = 1'b1;
                    state_d = IDLE;
                    ptr_d   = owner_q;
                    beat_d  = '0;
                end else begin
                    stall_d = stall_q + StallW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef PRIM_BURST_ARB_TIMEOUT_EN
        if (state_d != LOCK) begin
            stall_d = '0;
        end
`endif
        if (!rst_ni) begin
            gnt   = '0;
            idx   = '0;
            valid = 1'b0;
            data  = '0;
            last  = 1'b0;
            err   = 1'b0;
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.idx_o    = idx;
    assign bus.valid_o  = valid;
    assign bus.data_o   = data;
    assign bus.last_o   = last;
    assign bus.err_o    = err;
    assign bus.locked_o = rst_ni & (state_q == LOCK);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= IdxW'(N - 1);
            owner_q <= '0;
            beat_q  <= '0;
`ifdef PRIM_BURST_ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
`ifdef PRIM_BURST_ARB_TIMEOUT_EN
            stall_q <= stall_d;
`endif
        end
    end
endmodule

// File: tb/tb_prim_burst_arbiter.sv
// Directed bench for prim_burst_arbiter (N=4, MaxBeats=4, TimeoutCycles=8) with an
// expectation queue popped against the combinational outputs each cycle.
module tb_prim_burst_arbiter;
    localparam int unsigned N             = 4;
    localparam int unsigned DW            = 32;
    localparam int unsigned MaxBeats      = 4;
    localparam int unsigned TimeoutCycles = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prim_burst_arbiter_if #(.N(N), .DW(DW)) bus ();

    prim_burst_arbiter #(
        .N(N),
        .DW(DW),
        .MaxBeats(MaxBeats),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [3:0]  gnt;
        logic [1:0]  idx;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        locked;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   stepno = 0;

    function automatic logic [31:0] pay(int unsigned i, int s);
        return {8'(i + 1), 8'hA5, 16'(s)};
    endfunction

    task automatic chk(string tag, string f, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
        end
    endtask

    task automatic step(string tag, logic rst, logic [3:0] req, logic [3:0] lst, logic rdy,
                        logic [3:0] egnt, logic [1:0] eidx, logic ev, logic elast,
                        logic elock, logic eerr = 1'b0);
        exp_t e;
        exp_t o;
        @(negedge clk);
        stepno++;
        rst_n       = rst;
        bus.req_i   = req;
        bus.last_i  = lst;
        bus.ready_i = rdy;
        for (int i = 0; i < int'(N); i++) bus.data_i[i] = pay(i, stepno);
        e.tag    = tag;
        e.gnt    = egnt;
        e.idx    = eidx;
        e.valid  = ev;
        e.data   = (ev || elock) ? pay(eidx, stepno) : '0;
        e.last   = elast;
        e.locked = elock;
        e.err    = eerr;
        sb.push_back(e);
        #2;
        o = sb.pop_front();
        chk(o.tag, "gnt",    32'(bus.gnt_o),    32'(o.gnt));
        chk(o.tag, "idx",    32'(bus.idx_o),    32'(o.idx));
        chk(o.tag, "valid",  32'(bus.valid_o),  32'(o.valid));
        chk(o.tag, "data",   bus.data_o,        o.data);
        chk(o.tag, "last",   32'(bus.last_o),   32'(o.last));
        chk(o.tag, "locked", 32'(bus.locked_o), 32'(o.locked));
        chk(o.tag, "err",    32'(bus.err_o),    32'(o.err));
    endtask

    initial begin
        bus.req_i   = '0;
        bus.last_i  = '0;
        bus.ready_i = 1'b0;
        bus.data_i  = '0;

        // args: tag, rst_n, req, last, ready | gnt, idx, valid, last_o, locked
        step("rst0", 0, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
        step("rst1", 0, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
        step("idle", 1, 4'h0, 4'h0, 1, 4'h0, 3, 0, 0, 0);

        step("t1a", 1, 4'hF, 4'hF, 1, 4'h1, 0, 1, 1, 0);
        step("t1b", 1, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 0);
        step("t1c", 1, 4'hF, 4'hF, 1, 4'h4, 2, 1, 1, 0);
        step("t1d", 1, 4'hF, 4'hF, 1, 4'h8, 3, 1, 1, 0);

        step("t2a", 1, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 0);
        step("t2b", 1, 4'h3, 4'h0, 1, 4'h2, 1, 1, 0, 1);
        step("t2c", 1, 4'h3, 4'h0, 1, 4'h2, 1, 1, 0, 1);
        step("t2d", 1, 4'h3, 4'h2, 1, 4'h2, 1, 1, 1, 1);
        step("t2e", 1, 4'h1, 4'h1, 1, 4'h1, 0, 1, 1, 0);
        step("t2f", 1, 4'h4, 4'h0, 1, 4'h4, 2, 1, 0, 0);
        step("t2g", 1, 4'h4, 4'h4, 1, 4'h4, 2, 1, 1, 1);

        step("t3a", 1, 4'h1, 4'h0, 1, 4'h1, 0, 1, 0, 0);
        step("t3b", 1, 4'h1, 4'h0, 1, 4'h1, 0, 1, 0, 1);
        step("t3c", 1, 4'h1, 4'h0, 1, 4'h1, 0, 1, 0, 1);
        step("t3d", 1, 4'h1, 4'h0, 1, 4'h1, 0, 1, 1, 1);
        step("t3e", 1, 4'h9, 4'h9, 1, 4'h8, 3, 1, 1, 0);

        step("t4a", 1, 4'h4, 4'h0, 0, 4'h0, 2, 1, 0, 0);
        step("t4b", 1, 4'h5, 4'h0, 0, 4'h0, 2, 1, 0, 1);
        step("t4c", 1, 4'h5, 4'h0, 0, 4'h0, 2, 1, 0, 1);
        step("t4d", 1, 4'h5, 4'h4, 1, 4'h4, 2, 1, 1, 1);
        step("t4e", 1, 4'h1, 4'h1, 1, 4'h1, 0, 1, 1, 0);

        step("t5a", 1, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 0);
        step("t5b", 1, 4'h8, 4'h0, 1, 4'h0, 1, 0, 0, 1);
        step("t5c", 1, 4'h8, 4'h0, 1, 4'h0, 1, 0, 0, 1);
        step("t5d", 1, 4'hA, 4'h0, 1, 4'h2, 1, 1, 0, 1);
        step("t5e", 1, 4'hA, 4'h2, 1, 4'h2, 1, 1, 1, 1);
        step("t5f", 1, 4'h8, 4'h8, 1, 4'h8, 3, 1, 1, 0);

        step("rma", 1, 4'h1, 4'h0, 1, 4'h1, 0, 1, 0, 0);
        step("rmb", 0, 4'h1, 4'h0, 1, 4'h0, 0, 0, 0, 0);
        step("rmc", 1, 4'h3, 4'h3, 1, 4'h1, 0, 1, 1, 0);

        step("t6a", 1, 4'h2, 4'h0, 0, 4'h0, 1, 1, 0, 0);
`ifdef PRIM_BURST_ARB_TIMEOUT_EN
        for (int k = 1; k <= int'(TimeoutCycles); k++)
            step("t6s", 1, 4'h2, 4'h0, 0, 4'h0, 1, 1, 0, 1, (k == int'(TimeoutCycles)));
`else
        for (int k = 1; k <= int'(TimeoutCycles); k++)
            step("t6s", 1, 4'h2, 4'h0, 0, 4'h0, 1, 1, 0, 1, 1'b0);
        step("t6r", 1, 4'h2, 4'h2, 1, 4'h2, 1, 1, 1, 1);
`endif
        step("t6z", 1, 4'h3, 4'h3, 1, 4'h1, 0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
